// File: rtl/pkt_hdr_extract_pkg.sv
// rtl/pkt_hdr_extract_pkg.sv - shared types and constants for the packet header extractor
package pkt_hdr_extract_pkg;

    localparam logic [15:0] ETH_IPV4     = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL = 8'h45;
    localparam logic [7:0]  PROTO_TCP    = 8'd6;
    localparam logic [7:0]  PROTO_UDP    = 8'd17;
    localparam logic [2:0]  HDR_BEATS    = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_EMIT    = 2'd3
    } state_t;

    typedef struct packed {
        logic [47:0] eth_dst;
        logic [47:0] eth_src;
        logic [15:0] ethertype;
        logic        is_ipv4;
        logic [7:0]  ip_proto;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [15:0] l4_sport;
        logic [15:0] l4_dport;
        logic [15:0] pkt_len;
        logic        hdr_trunc;
        logic        hdr_err;
    } hdr_desc_t;

    // L4 ports are only meaningful for plain IPv4 carrying TCP or UDP
    function automatic logic has_l4_ports(input logic ipv4, input logic [7:0] proto);
        return ipv4 && ((proto == PROTO_TCP) || (proto == PROTO_UDP));
    endfunction

endpackage

// File: rtl/pkt_hdr_extract_if.sv
// rtl/pkt_hdr_extract_if.sv - packet input stream and header descriptor port bundle
interface pkt_hdr_extract_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int EMPTY_WIDTH = 3
) ();

    logic [DATA_WIDTH-1:0]  in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sop;
    logic                   in_eop;
    logic [EMPTY_WIDTH-1:0] in_empty;

    logic                   hdr_valid;
    logic                   hdr_ready;
    logic [47:0]            eth_dst;
    logic [47:0]            eth_src;
    logic [15:0]            ethertype;
    logic                   is_ipv4;
    logic [7:0]             ip_proto;
    logic [31:0]            ip_src;
    logic [31:0]            ip_dst;
    logic [15:0]            l4_sport;
    logic [15:0]            l4_dport;
    logic [15:0]            pkt_len;
    logic                   hdr_trunc;
    logic                   hdr_err;
    logic [15:0]            drop_cnt;

    // Extractor side: consumes the stream, produces descriptors
    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_empty, hdr_ready,
        output in_ready, hdr_valid, eth_dst, eth_src, ethertype, is_ipv4,
        output ip_proto, ip_src, ip_dst, l4_sport, l4_dport, pkt_len,
        output hdr_trunc, hdr_err, drop_cnt
    );

    // Source/sink side: drives the stream, consumes descriptors
    modport master (
        output in_data, in_valid, in_sop, in_eop, in_empty, hdr_ready,
        input  in_ready, hdr_valid, eth_dst, eth_src, ethertype, is_ipv4,
        input  ip_proto, ip_src, ip_dst, l4_sport, l4_dport, pkt_len,
        input  hdr_trunc, hdr_err, drop_cnt
    );

endinterface

// File: rtl/pkt_hdr_extract.sv
// rtl/pkt_hdr_extract.sv - extracts Ethernet/IPv4/L4 header fields and emits one descriptor per packet
module pkt_hdr_extract
    import pkt_hdr_extract_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int EMPTY_WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    pkt_hdr_extract_if.slave bus
);

    if (DATA_WIDTH != 64 || EMPTY_WIDTH != 3) begin : g_width_check
        $error("pkt_hdr_extract supports only DATA_WIDTH=64 with EMPTY_WIDTH=3");
    end

    state_t state, state_nxt;
    logic   ready;
    logic   accept;

    logic [2:0]  beat_cnt;
    logic [16:0] byte_cnt;
    logic [15:0] drop_cnt_q;
    logic        trunc_q;
    logic        err_q;

    logic [47:0] eth_dst_q;
    logic [47:0] eth_src_q;
    logic [15:0] ethertype_q;
    logic [7:0]  ver_ihl_q;
    logic [7:0]  ip_proto_q;
    logic [31:0] ip_src_q;
    logic [31:0] ip_dst_q;
    logic [15:0] sport_q;
    logic [15:0] dport_q;

    logic [DATA_WIDTH-1:0] keep_mask;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [EMPTY_WIDTH:0]  eop_bytes;
    logic [16:0]           beat_bytes;
    hdr_desc_t             desc;

    // Beat qualification: empty bytes of the EOP beat are zeroed so they never land in a field
    always_comb begin
        accept     = bus.in_valid && ready;
        keep_mask  = bus.in_eop ? ({DATA_WIDTH{1'b1}} << {bus.in_empty, 3'b000}) : {DATA_WIDTH{1'b1}};
        beat_data  = bus.in_data & keep_mask;
        eop_bytes  = (EMPTY_WIDTH+1)'(DATA_WIDTH/8) - {1'b0, bus.in_empty};
        beat_bytes = bus.in_eop ? 17'(eop_bytes) : 17'(DATA_WIDTH/8);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; a mid-packet SOP closes the current packet
    always_comb begin
        state_nxt = state;
        ready     = (state != ST_EMIT);
        case (state)
            ST_IDLE: begin
                if (accept && bus.in_sop) begin
                    state_nxt = bus.in_eop ? ST_EMIT : ST_HDR;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    if (bus.in_sop || bus.in_eop) begin
                        state_nxt = ST_EMIT;
                    end else if (beat_cnt == HDR_BEATS - 3'd1) begin
                        state_nxt = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept && (bus.in_sop || bus.in_eop)) begin
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (bus.hdr_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Header capture, byte/beat counting and drop accounting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt    <= '0;
            byte_cnt    <= '0;
            drop_cnt_q  <= '0;
            trunc_q     <= 1'b0;
            err_q       <= 1'b0;
            eth_dst_q   <= '0;
            eth_src_q   <= '0;
            ethertype_q <= '0;
            ver_ihl_q   <= '0;
            ip_proto_q  <= '0;
            ip_src_q    <= '0;
            ip_dst_q    <= '0;
            sport_q     <= '0;
            dport_q     <= '0;
        end else begin
            // Stray beat while idle, or an SOP that cuts a packet short
            if (accept && (bus.in_sop != (state == ST_IDLE))) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end

            if (accept && (state == ST_IDLE) && bus.in_sop) begin
                // New packet: clear everything so unreceived header bytes read as zero
                eth_dst_q   <= beat_data[63:16];
                eth_src_q   <= {beat_data[15:0], 32'h0};
                ethertype_q <= '0;
                ver_ihl_q   <= '0;
                ip_proto_q  <= '0;
                ip_src_q    <= '0;
                ip_dst_q    <= '0;
                sport_q     <= '0;
                dport_q     <= '0;
                beat_cnt    <= 3'd1;
                byte_cnt    <= beat_bytes;
                trunc_q     <= bus.in_eop;
                err_q       <= 1'b0;
            end else if (accept && (state != ST_IDLE)) begin
                if (bus.in_sop) begin
                    err_q <= 1'b1;
                end else begin
                    case (beat_cnt)
                        3'd1: begin
                            eth_src_q[31:0] <= beat_data[63:32];
                            ethertype_q     <= beat_data[31:16];
                            ver_ihl_q       <= beat_data[15:8];
                        end
                        3'd2: ip_proto_q <= beat_data[7:0];
                        3'd3: begin
                            ip_src_q        <= beat_data[47:16];
                            ip_dst_q[31:16] <= beat_data[15:0];
                        end
                        3'd4: begin
                            ip_dst_q[15:0] <= beat_data[63:48];
                            sport_q        <= beat_data[47:32];
                            dport_q        <= beat_data[31:16];
                        end
                        default: ;
                    endcase
                    if (beat_cnt != HDR_BEATS) begin
                        beat_cnt <= beat_cnt + 3'd1;
                    end
                    // Bit 16 set means the output already reads 16'hFFFF; stop counting
                    if (!byte_cnt[16]) begin
                        byte_cnt <= byte_cnt + beat_bytes;
                    end
                    if (bus.in_eop && (beat_cnt < HDR_BEATS - 3'd1)) begin
                        trunc_q <= 1'b1;
                    end
                end
            end
        end
    end

    // Descriptor assembly with IPv4 and L4-port qualification
    always_comb begin
        desc           = '0;
        desc.eth_dst   = eth_dst_q;
        desc.eth_src   = eth_src_q;
        desc.ethertype = ethertype_q;
        desc.is_ipv4   = (ethertype_q == ETH_IPV4) && (ver_ihl_q == IPV4_VER_IHL);
        desc.ip_proto  = ip_proto_q;
        desc.ip_src    = ip_src_q;
        desc.ip_dst    = ip_dst_q;
        if (has_l4_ports(desc.is_ipv4, ip_proto_q)) begin
            desc.l4_sport = sport_q;
            desc.l4_dport = dport_q;
        end
        desc.pkt_len   = byte_cnt[16] ? 16'hFFFF : byte_cnt[15:0];
        desc.hdr_trunc = trunc_q;
        desc.hdr_err   = err_q;
    end

    assign bus.in_ready  = ready;
    assign bus.hdr_valid = (state == ST_EMIT);
    assign bus.eth_dst   = desc.eth_dst;
    assign bus.eth_src   = desc.eth_src;
    assign bus.ethertype = desc.ethertype;
    assign bus.is_ipv4   = desc.is_ipv4;
    assign bus.ip_proto  = desc.ip_proto;
    assign bus.ip_src    = desc.ip_src;
    assign bus.ip_dst    = desc.ip_dst;
    assign bus.l4_sport  = desc.l4_sport;
    assign bus.l4_dport  = desc.l4_dport;
    assign bus.pkt_len   = desc.pkt_len;
    assign bus.hdr_trunc = desc.hdr_trunc;
    assign bus.hdr_err   = desc.hdr_err;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pkt_hdr_extract.sv
// tb/tb_pkt_hdr_extract.sv - directed self-checking bench for pkt_hdr_extract
module tb_pkt_hdr_extract;

    typedef struct {
        int          len;
        logic [15:0] etype;
        logic [7:0]  vihl;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] sp;
        logic [15:0] dp;
        logic [47:0] e_esrc;
        logic [15:0] e_etype;
        logic        e_ipv4;
        logic [7:0]  e_proto;
        logic [31:0] e_src;
        logic [31:0] e_dst;
        logic [15:0] e_sp;
        logic [15:0] e_dp;
        logic [15:0] e_len;
        logic        e_trunc;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t tbl [9];
    logic [7:0] pkt [0:127];

    pkt_hdr_extract_if #(.DATA_WIDTH(64), .EMPTY_WIDTH(3)) bus ();

    pkt_hdr_extract #(.DATA_WIDTH(64), .EMPTY_WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic build(input vec_t v);
        for (int i = 0; i < 128; i++) pkt[i] = 8'(i) ^ 8'hC3;
        pkt[0] = 8'h00; pkt[1] = 8'h11; pkt[2]  = 8'h22; pkt[3]  = 8'h33; pkt[4]  = 8'h44; pkt[5]  = 8'h55;
        pkt[6] = 8'h66; pkt[7] = 8'h77; pkt[8]  = 8'h88; pkt[9]  = 8'h99; pkt[10] = 8'hAA; pkt[11] = 8'hBB;
        pkt[12] = v.etype[15:8]; pkt[13] = v.etype[7:0];
        pkt[14] = v.vihl;
        pkt[23] = v.proto;
        pkt[26] = v.src[31:24]; pkt[27] = v.src[23:16]; pkt[28] = v.src[15:8]; pkt[29] = v.src[7:0];
        pkt[30] = v.dst[31:24]; pkt[31] = v.dst[23:16]; pkt[32] = v.dst[15:8]; pkt[33] = v.dst[7:0];
        pkt[34] = v.sp[15:8]; pkt[35] = v.sp[7:0];
        pkt[36] = v.dp[15:8]; pkt[37] = v.dp[7:0];
    endtask

    function automatic logic [63:0] word(input int k);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[63-8*j -: 8] = pkt[8*k+j];
        return w;
    endfunction

    task automatic drive_beat(input logic [63:0] d, input logic sop, input logic eop, input logic [2:0] empty);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_sop   = sop;
        bus.in_eop   = eop;
        bus.in_empty = empty;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_empty = 3'd0;
    endtask

    task automatic send_range(input int len, input int first, input int last);
        int nb;
        nb = (len + 7) / 8;
        for (int k = first; k < last; k++) begin
            drive_beat(word(k), k == 0, k == nb - 1, (k == nb - 1) ? 3'(nb * 8 - len) : 3'd0);
        end
    endtask

    task automatic send_pkt(input int len);
        send_range(len, 0, (len + 7) / 8);
    endtask

    task automatic wait_desc(input string t);
        int n;
        n = 0;
        while (!bus.hdr_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({t, ".wait_valid"}, 64'(bus.hdr_valid), 64'd1);
    endtask

    task automatic ack(input string t);
        bus.hdr_ready = 1'b1;
        @(posedge clk); #1;
        bus.hdr_ready = 1'b0;
        check({t, ".valid_drop"}, 64'(bus.hdr_valid), 64'd0);
    endtask

    task automatic check_vec(input vec_t v, input string t);
        check({t, ".eth_dst"},   64'(bus.eth_dst),   64'h0000_0011_2233_4455);
        check({t, ".eth_src"},   64'(bus.eth_src),   64'(v.e_esrc));
        check({t, ".ethertype"}, 64'(bus.ethertype), 64'(v.e_etype));
        check({t, ".is_ipv4"},   64'(bus.is_ipv4),   64'(v.e_ipv4));
        check({t, ".ip_proto"},  64'(bus.ip_proto),  64'(v.e_proto));
        check({t, ".ip_src"},    64'(bus.ip_src),    64'(v.e_src));
        check({t, ".ip_dst"},    64'(bus.ip_dst),    64'(v.e_dst));
        check({t, ".l4_sport"},  64'(bus.l4_sport),  64'(v.e_sp));
        check({t, ".l4_dport"},  64'(bus.l4_dport),  64'(v.e_dp));
        check({t, ".pkt_len"},   64'(bus.pkt_len),   64'(v.e_len));
        check({t, ".hdr_trunc"}, 64'(bus.hdr_trunc), 64'(v.e_trunc));
        check({t, ".hdr_err"},   64'(bus.hdr_err),   64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset         = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_sop    = 1'b0;
        bus.in_eop    = 1'b0;
        bus.in_empty  = '0;
        bus.hdr_ready = 1'b0;

        //        len etype     vihl   proto  src            dst            sp        dp         e_esrc              e_etype   ipv4  e_proto e_src          e_dst          e_sp      e_dp      e_len    trunc
        tbl[0] = '{60, 16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 48'h6677_8899_AABB, 16'h0800, 1'b1, 8'd17, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 16'd60, 1'b0};
        tbl[1] = '{20, 16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 48'h6677_8899_AABB, 16'h0800, 1'b1, 8'd0,  32'h0,        32'h0,        16'h0,    16'h0,    16'd20, 1'b1};
        tbl[2] = '{64, 16'h0806, 8'h45, 8'd17, 32'hC0A80001, 32'hC0A800FE, 16'h1111, 16'h2222, 48'h6677_8899_AABB, 16'h0806, 1'b0, 8'd17, 32'hC0A80001, 32'hC0A800FE, 16'h0,    16'h0,    16'd64, 1'b0};
        tbl[3] = '{40, 16'h0800, 8'h45, 8'd6,  32'hC0A80101, 32'hC0A80102, 16'h1F90, 16'hC350, 48'h6677_8899_AABB, 16'h0800, 1'b1, 8'd6,  32'hC0A80101, 32'hC0A80102, 16'h1F90, 16'hC350, 16'd40, 1'b0};
        tbl[4] = '{8,  16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 48'h6677_0000_0000, 16'h0000, 1'b0, 8'd0,  32'h0,        32'h0,        16'h0,    16'h0,    16'd8,  1'b1};
        tbl[5] = '{48, 16'h0800, 8'h46, 8'd17, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 48'h6677_8899_AABB, 16'h0800, 1'b0, 8'd17, 32'h0A000001, 32'h0A000002, 16'h0,    16'h0,    16'd48, 1'b0};
        tbl[6] = '{32, 16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 48'h6677_8899_AABB, 16'h0800, 1'b1, 8'd17, 32'h0A000001, 32'h0A000000, 16'h0,    16'h0,    16'd32, 1'b1};
        tbl[7] = '{38, 16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 48'h6677_8899_AABB, 16'h0800, 1'b1, 8'd17, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 16'd38, 1'b0};
        tbl[8] = '{61, 16'h0800, 8'h45, 8'd6,  32'hC0A80101, 32'hC0A80102, 16'h1F90, 16'hC350, 48'h6677_8899_AABB, 16'h0800, 1'b1, 8'd6,  32'hC0A80101, 32'hC0A80102, 16'h1F90, 16'hC350, 16'd61, 1'b0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst.hdr_valid", 64'(bus.hdr_valid), 64'd0);
        check("rst.drop_cnt",  64'(bus.drop_cnt),  64'd0);
        check("rst.pkt_len",   64'(bus.pkt_len),   64'd0);
        check("rst.eth_dst",   64'(bus.eth_dst),   64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst.in_ready", 64'(bus.in_ready), 64'd1);

        // Table of single packets
        for (int i = 0; i < 9; i++) begin
            build(tbl[i]);
            send_pkt(tbl[i].len);
            check($sformatf("vec%0d.latency", i), 64'(bus.hdr_valid), 64'd1);
            check_vec(tbl[i], $sformatf("vec%0d", i));
            ack($sformatf("vec%0d", i));
        end
        check("tbl.drop_cnt", 64'(bus.drop_cnt), 64'd0);

        // Backpressure with a second packet queued behind the descriptor
        build(tbl[0]);
        send_pkt(60);
        check("bp.latency", 64'(bus.hdr_valid), 64'd1);
        build(tbl[2]);
        fork
            begin
                send_pkt(64);
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    check("bp.in_ready",  64'(bus.in_ready),  64'd0);
                    check("bp.hdr_valid", 64'(bus.hdr_valid), 64'd1);
                    check("bp.pkt_len",   64'(bus.pkt_len),   64'd60);
                    check("bp.ip_src",    64'(bus.ip_src),    64'h0A000001);
                    @(posedge clk); #1;
                end
                ack("bp.first");
                wait_desc("bp.second");
                check_vec(tbl[2], "bp.second");
                ack("bp.second");
            end
        join

        // Idle drops, then a packet cut short by a SOP in its third beat
        drive_beat(64'hDEAD_0000_0000_0001, 1'b0, 1'b0, 3'd0);
        drive_beat(64'hBEEF_0000_0000_0002, 1'b0, 1'b0, 3'd0);
        check("drop.idle", 64'(bus.drop_cnt), 64'd2);
        build(tbl[0]);
        drive_beat(word(0), 1'b1, 1'b0, 3'd0);
        drive_beat(word(1), 1'b0, 1'b0, 3'd0);
        drive_beat(word(2), 1'b1, 1'b0, 3'd0);
        check("err.hdr_valid", 64'(bus.hdr_valid), 64'd1);
        check("err.hdr_err",   64'(bus.hdr_err),   64'd1);
        check("err.pkt_len",   64'(bus.pkt_len),   64'd16);
        check("err.drop_cnt",  64'(bus.drop_cnt),  64'd3);
        check("err.ethertype", 64'(bus.ethertype), 64'h0800);
        check("err.ip_proto",  64'(bus.ip_proto),  64'd0);
        ack("err");

        // Byte count saturation on a very long packet
        drive_beat(word(0), 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 8200; i++) drive_beat(64'h0, 1'b0, 1'b0, 3'd0);
        drive_beat(64'h0, 1'b0, 1'b1, 3'd0);
        check("sat.pkt_len",   64'(bus.pkt_len),   64'hFFFF);
        check("sat.hdr_trunc", 64'(bus.hdr_trunc), 64'd0);
        check("sat.hdr_err",   64'(bus.hdr_err),   64'd0);
        check("sat.drop_cnt",  64'(bus.drop_cnt),  64'd3);
        ack("sat");

        // Asynchronous reset in the middle of the payload
        build(tbl[0]);
        send_range(60, 0, 6);
        check("arst.pre_drop", 64'(bus.drop_cnt), 64'd3);
        reset = 1'b1;
        #1;
        check("arst.hdr_valid", 64'(bus.hdr_valid), 64'd0);
        check("arst.drop_cnt",  64'(bus.drop_cnt),  64'd0);
        check("arst.pkt_len",   64'(bus.pkt_len),   64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        send_pkt(60);
        check("arst.latency", 64'(bus.hdr_valid), 64'd1);
        check_vec(tbl[0], "arst.clean");
        ack("arst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
